// File: rtl/gearbox_rx_pkg.sv
// Shared PCS constants for the 64b/66b receive gearbox and its neighbours.
package gearbox_rx_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned HEAD_W    = 2;
    localparam int unsigned BLOCK_W   = 66;
    localparam int unsigned GB_RES_W  = 7;
    localparam int unsigned GB_MAX_W  = 129;
    localparam int unsigned GB_PERIOD = 33;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

endpackage

// File: rtl/gearbox_shift_rx.sv
// Builds the working vector {data, residue}, then applies an optional one-bit slip.
module gearbox_shift_rx #(
    parameter int unsigned DATA_W = gearbox_rx_pkg::DATA_W,
    parameter int unsigned HEAD_W = gearbox_rx_pkg::HEAD_W,
    localparam int unsigned BLK_W = DATA_W + HEAD_W,
    localparam int unsigned RES_N = BLK_W - 1,
    localparam int unsigned RES_W = $clog2(BLK_W),
    localparam int unsigned MAX_W = RES_N + DATA_W,
    localparam int unsigned CNT_W = $clog2(MAX_W + 1)
) (
    input  logic [RES_N-1:0]  i_res,
    input  logic [RES_W-1:0]  i_res_cnt,
    input  logic              i_data_v,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_slip,
    output logic [MAX_W-1:0]  o_work_c,
    output logic [CNT_W-1:0]  o_cnt_c
);

    logic [MAX_W-1:0] w_work;
    logic [CNT_W-1:0] w_cnt;

    // Residue bits above i_res_cnt are always zero, so a plain OR places the new word.
    always_comb begin
        w_work = MAX_W'(i_res);
        w_cnt  = CNT_W'(i_res_cnt);
        if (i_data_v) begin
            w_work = w_work | (MAX_W'(i_data) << i_res_cnt);
            w_cnt  = w_cnt + CNT_W'(DATA_W);
        end
        if (i_slip && (w_cnt != '0)) begin
            w_work = w_work >> 1;
            w_cnt  = w_cnt - CNT_W'(1);
        end
    end

    assign o_work_c = w_work;
    assign o_cnt_c  = w_cnt;

endmodule

// File: rtl/gearbox_rx.sv
// 64b->66b receive gearbox: accumulates SERDES words and emits 66-bit blocks,
// honouring bit-slip requests from block sync.
module gearbox_rx #(
    parameter int unsigned DATA_W = gearbox_rx_pkg::DATA_W,
    parameter int unsigned HEAD_W = gearbox_rx_pkg::HEAD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_v_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              slip_v_i,
    output logic              valid_o,
    output logic [HEAD_W-1:0] head_o,
    output logic [DATA_W-1:0] data_o
);

    localparam int unsigned BLK_W = DATA_W + HEAD_W;
    localparam int unsigned RES_N = BLK_W - 1;
    localparam int unsigned RES_W = $clog2(BLK_W);
    localparam int unsigned MAX_W = RES_N + DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W + 1);

    logic [RES_N-1:0]  r_res;
    logic [RES_W-1:0]  r_cnt;
    logic              r_valid;
    logic [HEAD_W-1:0] r_head;
    logic [DATA_W-1:0] r_data;

    logic [MAX_W-1:0]  w_work;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_emit;

    gearbox_shift_rx #(
        .DATA_W (DATA_W),
        .HEAD_W (HEAD_W)
    ) u_shift (
        .i_res     (r_res),
        .i_res_cnt (r_cnt),
        .i_data_v  (data_v_i),
        .i_data    (data_i),
        .i_slip    (slip_v_i),
        .o_work_c  (w_work),
        .o_cnt_c   (w_cnt)
    );

    assign w_emit = (w_cnt >= CNT_W'(BLK_W));

    // Block extraction and residue update; head/data hold on stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_data  <= '0;
        end else if (w_emit) begin
            r_valid <= 1'b1;
            r_head  <= w_work[HEAD_W-1:0];
            r_data  <= w_work[BLK_W-1:HEAD_W];
            r_res   <= RES_N'(w_work >> BLK_W);
            r_cnt   <= RES_W'(w_cnt - CNT_W'(BLK_W));
        end else begin
            r_valid <= 1'b0;
            r_res   <= RES_N'(w_work);
            r_cnt   <= RES_W'(w_cnt);
        end
    end

    assign valid_o = r_valid;
    assign head_o  = r_head;
    assign data_o  = r_data;

endmodule

// File: doc/gearbox_rx.md
Name: gearbox_rx

Overview:
- 64b→66b receive gearbox with bit-slip, sitting directly upstream of the per-lane block sync.
- Accepts one 64-bit SERDES word per cycle and emits registered 66-bit blocks, split into a 2-bit sync header and a 64-bit payload.
- Consumes the slip request from block sync: each slip discards one received bit, shifting block alignment by one bit position.

Parameters:
- DATA_W, 64, SERDES word width and block payload width.
- HEAD_W, 2, sync header width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- data_v_i  in  1  SERDES word valid; when 0, data_i is ignored.
- data_i  in  DATA_W  SERDES word; bit 0 received first.
- slip_v_i  in  1  slip request from block sync: discard one bit at this edge.
- valid_o  out  1  block valid (registered).
- head_o  out  HEAD_W  block bits [1:0] (registered).
- data_o  out  DATA_W  block bits [65:2] (registered).

Behaviour:
- State: residue count r (0..65, 7 bits) and residue bits R (oldest bit at index 0). Working vector W = {data_i, R[r-1:0]}, up to 129 bits.
- Per edge (no reset):
  - n = r + (data_v_i ? 64 : 0).
  - If slip_v_i and n>0: drop W[0] (shift W down 1), n = n-1.
  - If slip_v_i and n==0: the slip is a no-op.
  - If n>=66: block = W[65:0]; valid_o<=1, head_o<=W[1:0], data_o<=W[65:2]; R<=W>>66, r<=n-66.
  - Else: valid_o<=0, head_o/data_o hold their previous values, R<=W, r<=n.
- Slip is applied before extraction at the same edge. block sync drives slip_v_i combinationally from the registered head_o, so the next emitted block is one bit later in the stream.
- Steady state, data_v_i=1 and no slips:
  - From r=0, the first edge gives r=64 with no block.
  - Each later edge emits one block and r falls by 2.
  - Repeating cadence: 33 cycles, 32 valid blocks, 1 stall (when r=0).
- Slips can make r odd. r=1 with no output gives r=65, so the next word gives n=129. The 129-bit W is the maximum and must never overflow.
- Latency: a block is on the outputs the cycle after the edge that accepted its last bit.
- data_v_i=0 with no slip: R and r are held, valid_o<=0.
- Reset (synchronous, priority over all): r<=0, R<=0, valid_o<=0, head_o<=0, data_o<=0. Reset mid-stream discards the residue.
- Mod-66 property: 66 slips with no other bit loss return to the original block alignment.
- No error outputs. Header validity (01/10) is judged downstream, not here.

Decomposition:
- Shared PCS package holds:
  - constants DATA_W=64, HEAD_W=2, BLOCK_W=66, GB_RES_W=7, GB_MAX_W=129, GB_PERIOD=33;
  - sync header localparams SH_DATA=2'b01, SH_CTRL=2'b10.
- Single module. Extraction is a variable right shift by r and by slip. No sub-module is needed; optionally factor the shifter as gearbox_shift_rx.

Test Plan:
- Reset then 33 aligned words from a 32-block stream (head 01 or 10, incrementing payload):
  - first valid_o two edges after reset deasserts;
  - exactly 32 valid blocks in 33 cycles;
  - head_o and data_o match the source in order.
- Stream offset by 5 bits, slip_v_i pulsed on 5 valid-block cycles: subsequent blocks are bit-exact aligned, with head_o always 01/10.
- 66 consecutive slips on an aligned stream: alignment returns, and the next block equals the source block 66 bits later.
- data_v_i=0 for 3 cycles at r=34: valid_o=0 for those cycles, r held at 34, and the following blocks are uncorrupted.
- Reset asserted at r=34 mid-stream:
  - next cycle valid_o=0, head_o=0, data_o=0;
  - after release the cadence restarts from r=0.
- Drive to r=1 via slips, then two words without slip:
  - r=65, then n=129 gives a block with r=63;
  - slip with data_v_i=0 and r=0 leaves r=0.
